// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// params_pkg : shared widths and the memory access-size encoding.
// ex_stage   : execute stage feeding the EX/MEM pipeline register.
//
// ex_stage computes a single-cycle ALU result, or runs a 32-iteration
// restoring divider for DIV/DIVU/REM/REMU, and registers the EX/MEM fields.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-low reset
//   valid_i               decode presents an instruction
//   alu_op_i              operation select (see OP_* below)
//   op_a_i, op_b_i        operands
//   rs2_data_i            store data, passed through
//   wr_reg_i              destination register
//   is_load_i, is_store_i load / store flags
//   reg_wr_en_i           register write enable
//   access_size_i         memory access size, passed through
//   stall_i               memory stage stall
//   flush_i               kill the instruction in EX
//   stall_o               EX did not consume this cycle's input
//   mem_*_o               registered EX/MEM fields
// ---------------------------------------------------------------------------
package params_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REGISTER_WIDTH = 5;

    typedef logic [1:0] access_size_t;

    localparam access_size_t SIZE_BYTE = 2'd0;
    localparam access_size_t SIZE_HALF = 2'd1;
    localparam access_size_t SIZE_WORD = 2'd2;
endpackage

module ex_stage #(
    parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic [3:0]                   alu_op_i,
    input  logic [DATA_WIDTH-1:0]        op_a_i,
    input  logic [DATA_WIDTH-1:0]        op_b_i,
    input  logic [DATA_WIDTH-1:0]        rs2_data_i,
    input  logic [REGISTER_WIDTH-1:0]    wr_reg_i,
    input  logic                         is_load_i,
    input  logic                         is_store_i,
    input  logic                         reg_wr_en_i,
    input  params_pkg::access_size_t     access_size_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    output logic                         stall_o,
    output logic                         mem_valid_o,
    output logic                         mem_is_load_o,
    output logic                         mem_is_store_o,
    output logic                         mem_reg_wr_en_o,
    output logic [DATA_WIDTH-1:0]        mem_alu_result_o,
    output logic [DATA_WIDTH-1:0]        mem_rs2_data_o,
    output logic [REGISTER_WIDTH-1:0]    mem_wr_reg_o,
    output params_pkg::access_size_t     mem_access_size_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REM   = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] SIGN_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_LAST = {CNT_W{1'b1}};

    // Divider state
    logic [1:0]             state_q,   state_d;
    logic [CNT_W-1:0]       count_q,   count_d;
    logic [3:0]             div_op_q,  div_op_d;
    logic [DATA_WIDTH-1:0]  quot_q,    quot_d;
    logic [DATA_WIDTH-1:0]  rem_q,     rem_d;
    logic [DATA_WIDTH-1:0]  divisor_q, divisor_d;
    logic                   sign_a_q,  sign_a_d;
    logic                   sign_b_q,  sign_b_d;

    // EX/MEM register
    logic                         mem_valid_q;
    logic                         mem_is_load_q;
    logic                         mem_is_store_q;
    logic                         mem_reg_wr_en_q;
    logic [DATA_WIDTH-1:0]        mem_alu_result_q;
    logic [DATA_WIDTH-1:0]        mem_rs2_data_q;
    logic [REGISTER_WIDTH-1:0]    mem_wr_reg_q;
    params_pkg::access_size_t     mem_access_size_q;

    // Combinational helpers
    logic [CNT_W-1:0]       shamt_s;
    logic                   slt_s;
    logic                   sltu_s;
    logic                   is_div_op_s;
    logic                   div_signed_s;
    logic                   div_zero_s;
    logic                   div_ovf_s;
    logic                   div_start_s;
    logic                   accept_s;
    logic [DATA_WIDTH-1:0]  abs_a_s;
    logic [DATA_WIDTH-1:0]  abs_b_s;
    logic [DATA_WIDTH:0]    rem_shift_s;
    logic [DATA_WIDTH:0]    diff_s;
    logic [DATA_WIDTH-1:0]  quot_fix_s;
    logic [DATA_WIDTH-1:0]  rem_fix_s;
    logic [DATA_WIDTH-1:0]  div_result_s;
    logic [DATA_WIDTH-1:0]  alu_result_s;
    logic [DATA_WIDTH-1:0]  result_s;

    assign shamt_s      = op_b_i[CNT_W-1:0];
    assign slt_s        = $signed(op_a_i) < $signed(op_b_i);
    assign sltu_s       = op_a_i < op_b_i;
    assign is_div_op_s  = (alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU) ||
                          (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
    assign div_signed_s = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
    assign div_zero_s   = (op_b_i == ZERO);
    assign div_ovf_s    = div_signed_s && (op_a_i == SIGN_MIN) && (op_b_i == ALL_ONES);

    // Zero divisor and signed overflow resolve in one cycle without the FSM.
    assign div_start_s  = (state_q == ST_IDLE) && valid_i && is_div_op_s && !stall_i &&
                          !flush_i && !div_zero_s && !div_ovf_s;

    assign stall_o  = stall_i || (state_q == ST_BUSY) ||
                      ((state_q == ST_DONE) && stall_i) || div_start_s;
    assign accept_s = valid_i && !stall_o && !flush_i;

    assign abs_a_s = (div_signed_s && op_a_i[DATA_WIDTH-1]) ? (ZERO - op_a_i) : op_a_i;
    assign abs_b_s = (div_signed_s && op_b_i[DATA_WIDTH-1]) ? (ZERO - op_b_i) : op_b_i;

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor; a clear borrow bit means the subtraction fits.
    assign rem_shift_s = {rem_q, quot_q[DATA_WIDTH-1]};
    assign diff_s      = rem_shift_s - {1'b0, divisor_q};

    // Sign bits were only latched for signed ops, so unsigned ops pass unchanged.
    assign quot_fix_s   = (sign_a_q ^ sign_b_q) ? (ZERO - quot_q) : quot_q;
    assign rem_fix_s    = sign_a_q ? (ZERO - rem_q) : rem_q;
    assign div_result_s = ((div_op_q == OP_DIV) || (div_op_q == OP_DIVU)) ? quot_fix_s : rem_fix_s;

    assign result_s = (state_q == ST_DONE) ? div_result_s : alu_result_s;

    // Single-cycle ALU, including the divider's one-cycle special cases
    always_comb begin
        alu_result_s = ZERO;
        case (alu_op_i)
            OP_ADD:   alu_result_s = op_a_i + op_b_i;
            OP_SUB:   alu_result_s = op_a_i - op_b_i;
            OP_AND:   alu_result_s = op_a_i & op_b_i;
            OP_OR:    alu_result_s = op_a_i | op_b_i;
            OP_XOR:   alu_result_s = op_a_i ^ op_b_i;
            OP_SLL:   alu_result_s = op_a_i << shamt_s;
            OP_SRL:   alu_result_s = op_a_i >> shamt_s;
            OP_SRA:   alu_result_s = $unsigned($signed(op_a_i) >>> shamt_s);
            OP_SLT:   alu_result_s = {{(DATA_WIDTH-1){1'b0}}, slt_s};
            OP_SLTU:  alu_result_s = {{(DATA_WIDTH-1){1'b0}}, sltu_s};
            OP_MUL:   alu_result_s = op_a_i * op_b_i;
            OP_DIV,
            OP_DIVU:  alu_result_s = div_zero_s ? ALL_ONES : SIGN_MIN;
            OP_REM,
            OP_REMU:  alu_result_s = div_zero_s ? op_a_i : ZERO;
            OP_PASSB: alu_result_s = op_b_i;
            default:  alu_result_s = op_b_i;
        endcase
    end

    // Divider FSM next-state; flush overrides everything
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        div_op_d  = div_op_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (div_start_s) begin
                        state_d   = ST_BUSY;
                        count_d   = {CNT_W{1'b0}};
                        div_op_d  = alu_op_i;
                        quot_d    = abs_a_s;
                        rem_d     = ZERO;
                        divisor_d = abs_b_s;
                        sign_a_d  = div_signed_s & op_a_i[DATA_WIDTH-1];
                        sign_b_d  = div_signed_s & op_b_i[DATA_WIDTH-1];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!diff_s[DATA_WIDTH]) begin
                        rem_d  = diff_s[DATA_WIDTH-1:0];
                        quot_d = {quot_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d  = rem_shift_s[DATA_WIDTH-1:0];
                        quot_d = {quot_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q + CNT_ONE;
                    if (count_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (!stall_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Divider registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            count_q   <= {CNT_W{1'b0}};
            div_op_q  <= 4'd0;
            quot_q    <= ZERO;
            rem_q     <= ZERO;
            divisor_q <= ZERO;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_op_q  <= div_op_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
        end
    end

    // EX/MEM pipeline register: hold on memory stall, load on accept, else drop valid
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_valid_q       <= 1'b0;
            mem_is_load_q     <= 1'b0;
            mem_is_store_q    <= 1'b0;
            mem_reg_wr_en_q   <= 1'b0;
            mem_alu_result_q  <= ZERO;
            mem_rs2_data_q    <= ZERO;
            mem_wr_reg_q      <= {REGISTER_WIDTH{1'b0}};
            mem_access_size_q <= 2'd0;
        end else if (stall_i) begin
            mem_valid_q       <= mem_valid_q;
        end else if (accept_s) begin
            mem_valid_q       <= 1'b1;
            mem_is_load_q     <= is_load_i;
            mem_is_store_q    <= is_store_i;
            mem_reg_wr_en_q   <= reg_wr_en_i;
            mem_alu_result_q  <= result_s;
            mem_rs2_data_q    <= rs2_data_i;
            mem_wr_reg_q      <= wr_reg_i;
            mem_access_size_q <= access_size_i;
        end else begin
            mem_valid_q       <= 1'b0;
        end
    end

    assign mem_valid_o       = mem_valid_q;
    assign mem_is_load_o     = mem_is_load_q;
    assign mem_is_store_o    = mem_is_store_q;
    assign mem_reg_wr_en_o   = mem_reg_wr_en_q;
    assign mem_alu_result_o  = mem_alu_result_q;
    assign mem_rs2_data_o    = mem_rs2_data_q;
    assign mem_wr_reg_o      = mem_wr_reg_q;
    assign mem_access_size_o = mem_access_size_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ex_stage: directed scenarios followed by random
// instructions compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ex_stage;
    import params_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [3:0]  alu_op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  wr_reg_i;
    logic        is_load_i;
    logic        is_store_i;
    logic        reg_wr_en_i;
    logic [1:0]  access_size_i;
    logic        stall_i;
    logic        flush_i;
    logic        stall_o;
    logic        mem_valid_o;
    logic        mem_is_load_o;
    logic        mem_is_store_o;
    logic        mem_reg_wr_en_o;
    logic [31:0] mem_alu_result_o;
    logic [31:0] mem_rs2_data_o;
    logic [4:0]  mem_wr_reg_o;
    logic [1:0]  mem_access_size_o;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .alu_op_i(alu_op_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .rs2_data_i(rs2_data_i), .wr_reg_i(wr_reg_i),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .reg_wr_en_i(reg_wr_en_i),
        .access_size_i(access_size_i), .stall_i(stall_i), .flush_i(flush_i),
        .stall_o(stall_o), .mem_valid_o(mem_valid_o), .mem_is_load_o(mem_is_load_o),
        .mem_is_store_o(mem_is_store_o), .mem_reg_wr_en_o(mem_reg_wr_en_o),
        .mem_alu_result_o(mem_alu_result_o), .mem_rs2_data_o(mem_rs2_data_o),
        .mem_wr_reg_o(mem_wr_reg_o), .mem_access_size_o(mem_access_size_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wr, input logic ld, input logic st, input logic we,
                         input logic [1:0] sz, input logic [31:0] rs2);
        valid_i = 1'b1; alu_op_i = op; op_a_i = a; op_b_i = b; wr_reg_i = wr;
        is_load_i = ld; is_store_i = st; reg_wr_en_i = we; access_size_i = sz; rs2_data_i = rs2;
    endtask

    task automatic idle();
        valid_i = 1'b0; alu_op_i = 4'd0; op_a_i = 32'd0; op_b_i = 32'd0; wr_reg_i = 5'd0;
        is_load_i = 1'b0; is_store_i = 1'b0; reg_wr_en_i = 1'b0; access_size_i = 2'd0;
        rs2_data_i = 32'd0;
    endtask

    // Reference model: results from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return 32'(ua + ub);
            4'd1:  return 32'(ua - ub);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return 32'(ua * (64'sd1 <<< sh));
            4'd6:  return 32'(ua / (64'sd1 <<< sh));
            4'd7:  return 32'(sa >>> sh);
            4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd10: return 32'(ua * ub);
            4'd11: if (b == 32'd0) return 32'hFFFFFFFF; else return 32'(sa / sb);
            4'd12: if (b == 32'd0) return 32'hFFFFFFFF; else return 32'(ua / ub);
            4'd13: if (b == 32'd0) return a; else return 32'(sa % sb);
            4'd14: if (b == 32'd0) return a; else return 32'(ua % ub);
            default: return b;
        endcase
    endfunction

    // Divide with no memory stall: stall_o high for 33 cycles, result after 34.
    task automatic div_directed(input string tag, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp);
        int bad_stall;
        bad_stall = 0;
        drive(op, a, b, 5'd7, 1'b0, 1'b0, 1'b1, SIZE_WORD, 32'd0);
        #1;
        for (int i = 0; i < 33; i++) begin
            if (stall_o !== 1'b1) bad_stall++;
            tick();
        end
        chk({tag, " stall_high_cycles"}, bad_stall, 0);
        chk({tag, " stall_low_n33"}, stall_o, 1'b0);
        chk({tag, " no_early_valid"}, mem_valid_o, 1'b0);
        tick();
        idle();
        chk({tag, " valid"}, mem_valid_o, 1'b1);
        chk({tag, " result"}, mem_alu_result_o, exp);
        chk({tag, " wr_reg"}, mem_wr_reg_o, 5'd7);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, rs2, exp;
        logic [4:0]  wr;
        logic        ld, st, we;
        logic [1:0]  sz;
        int          cyc, stalls_left, ghost;

        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        idle();
        #3;
        // Reset state
        chk("rst valid", mem_valid_o, 1'b0);
        chk("rst result", mem_alu_result_o, 32'd0);
        chk("rst wr_reg", mem_wr_reg_o, 5'd0);
        chk("rst rs2", mem_rs2_data_o, 32'd0);
        stall_i = 1'b1; #1;
        chk("rst stall follows 1", stall_o, 1'b1);
        stall_i = 1'b0; #1;
        chk("rst stall follows 0", stall_o, 1'b0);
        tick(); tick();
        rst_i = 1'b1;
        tick();

        // ADD 5+7 -> 12
        drive(4'd0, 32'd5, 32'd7, 5'd3, 1'b0, 1'b0, 1'b1, SIZE_WORD, 32'd0);
        #1;
        chk("add stall", stall_o, 1'b0);
        tick();
        idle(); #1;
        chk("add stall after", stall_o, 1'b0);
        chk("add valid", mem_valid_o, 1'b1);
        chk("add result", mem_alu_result_o, 32'd12);
        chk("add wr_reg", mem_wr_reg_o, 5'd3);
        tick();
        chk("add valid drops", mem_valid_o, 1'b0);
        chk("add result holds", mem_alu_result_o, 32'd12);

        // Iterative divides
        div_directed("div -7/2", 4'd11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        div_directed("rem -7/2", 4'd13, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        div_directed("divu 100/7", 4'd12, 32'd100, 32'd7, 32'd14);

        // One-cycle divide special cases
        drive(4'd12, 32'd9, 32'd0, 5'd8, 1'b0, 1'b0, 1'b1, SIZE_WORD, 32'd0);
        #1;
        chk("divu0 stall", stall_o, 1'b0);
        tick();
        chk("divu0 result", mem_alu_result_o, 32'hFFFFFFFF);
        chk("divu0 valid", mem_valid_o, 1'b1);
        drive(4'd13, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1'b0, 1'b0, 1'b1, SIZE_WORD, 32'd0);
        #1;
        chk("removf stall", stall_o, 1'b0);
        tick();
        chk("removf result", mem_alu_result_o, 32'd0);
        chk("removf wr_reg", mem_wr_reg_o, 5'd9);

        // Store held by memory stall for 3 cycles
        drive(4'd0, 32'h1000, 32'h20, 5'd0, 1'b0, 1'b1, 1'b0, SIZE_WORD, 32'hDEADBEEF);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st stall_o", stall_o, 1'b1);
            tick();
            chk("st hold valid", mem_valid_o, 1'b1);
            chk("st hold result", mem_alu_result_o, 32'd0);
            chk("st hold wr_reg", mem_wr_reg_o, 5'd9);
            chk("st hold is_store", mem_is_store_o, 1'b0);
        end
        stall_i = 1'b0; #1;
        chk("st stall released", stall_o, 1'b0);
        tick();
        idle();
        chk("st valid", mem_valid_o, 1'b1);
        chk("st addr", mem_alu_result_o, 32'h1020);
        chk("st data", mem_rs2_data_o, 32'hDEADBEEF);
        chk("st is_store", mem_is_store_o, 1'b1);
        chk("st wr_en", mem_reg_wr_en_o, 1'b0);
        chk("st size", mem_access_size_o, SIZE_WORD);
        tick();

        // Flush at BUSY count 10
        drive(4'd11, 32'd100, 32'd3, 5'd6, 1'b0, 1'b0, 1'b1, SIZE_WORD, 32'd0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        flush_i = 1'b1; #1;
        chk("flush busy stall", stall_o, 1'b1);
        tick();
        flush_i = 1'b0;
        idle(); #1;
        chk("flush idle stall", stall_o, 1'b0);
        drive(4'd0, 32'd1, 32'd2, 5'd4, 1'b0, 1'b0, 1'b1, SIZE_WORD, 32'd0);
        #1;
        chk("post flush add stall", stall_o, 1'b0);
        tick();
        idle();
        chk("post flush add valid", mem_valid_o, 1'b1);
        chk("post flush add result", mem_alu_result_o, 32'd3);
        ghost = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_valid_o !== 1'b0) ghost++;
        end
        chk("flush no ghost result", ghost, 0);

        // Reset during BUSY
        drive(4'd11, 32'd50, 32'd7, 5'd5, 1'b0, 1'b0, 1'b1, SIZE_WORD, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        rst_i = 1'b0;
        idle(); #1;
        chk("midrst result", mem_alu_result_o, 32'd0);
        chk("midrst wr_reg", mem_wr_reg_o, 5'd0);
        chk("midrst wr_en", mem_reg_wr_en_o, 1'b0);
        chk("midrst stall", stall_o, 1'b0);
        tick();
        rst_i = 1'b1;
        tick();
        chk("midrst no partial", mem_valid_o, 1'b0);
        div_directed("div 20/3", 4'd11, 32'd20, 32'd3, 32'd6);

        // Random instructions with occasional memory stalls
        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'h80000000;
                default: b = b;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h80000000;
            wr  = 5'($urandom);
            ld  = 1'($urandom);
            st  = 1'($urandom);
            we  = 1'($urandom);
            sz  = 2'($urandom_range(0, 2));
            rs2 = $urandom;
            exp = ref_result(op, a, b);
            drive(op, a, b, wr, ld, st, we, sz, rs2);
            stalls_left = $urandom_range(0, 4);
            cyc = 0;
            if (stalls_left > 0 && $urandom_range(0, 1) == 1) begin
                stall_i = 1'b1; stalls_left--;
            end else begin
                stall_i = 1'b0;
            end
            #1;
            while (stall_o && cyc < 80) begin
                @(posedge clk_i);
                #1;
                cyc++;
                if (stalls_left > 0 && $urandom_range(0, 1) == 1) begin
                    stall_i = 1'b1; stalls_left--;
                end else begin
                    stall_i = 1'b0;
                end
                #1;
            end
            chk("rand accept timeout", stall_o, 1'b0);
            tick();
            idle();
            chk("rand valid", mem_valid_o, 1'b1);
            chk("rand result", mem_alu_result_o, exp);
            chk("rand wr_reg", mem_wr_reg_o, wr);
            chk("rand flags", {mem_is_load_o, mem_is_store_o, mem_reg_wr_en_o}, {ld, st, we});
            chk("rand size", mem_access_size_o, sz);
            chk("rand rs2", mem_rs2_data_o, rs2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage directly upstream of the memory stage. It computes the ALU result for one instruction per cycle and runs an iterative 32-cycle restoring divider for DIV/DIVU/REM/REMU. It drives the registered EX/MEM pipeline fields: address/result, store data, destination register, load/store/write-enable flags and access size. It back-pressures decode while busy or while the memory stage stalls.

Parameters:
DATA_WIDTH, params_pkg::DATA_WIDTH (32), operand/result width; divider iteration count equals DATA_WIDTH
REGISTER_WIDTH, params_pkg::REGISTER_WIDTH (5), destination register index width

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
valid_i  in  1  decode presents a valid instruction
alu_op_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 DIV, 12 DIVU, 13 REM, 14 REMU, 15 PASSB
op_a_i  in  DATA_WIDTH  operand A
op_b_i  in  DATA_WIDTH  operand B (register or immediate)
rs2_data_i  in  DATA_WIDTH  store data, passed through
wr_reg_i  in  REGISTER_WIDTH  destination register
is_load_i  in  1  load flag
is_store_i  in  1  store flag
reg_wr_en_i  in  1  register write enable
access_size_i  in  access_size_t  passed through
stall_i  in  1  memory stage stall
flush_i  in  1  kill the instruction in EX
stall_o  out  1  EX did not consume this cycle's input; decode holds it
mem_valid_o, mem_is_load_o, mem_is_store_o, mem_reg_wr_en_o  out  1 each  registered EX/MEM flags
mem_alu_result_o, mem_rs2_data_o  out  DATA_WIDTH  registered result, store data
mem_wr_reg_o  out  REGISTER_WIDTH  registered destination
mem_access_size_o  out  access_size_t  registered size

Behaviour:
- Reset (async, rst_i=0): all mem_* outputs 0; state IDLE; divider registers 0. stall_o follows stall_i.
- Accept condition: valid_i && !stall_o && !flush_i. On accept, all mem_* fields load from the inputs plus the result, and mem_valid_o=1.
- Output register behaviour:
  - stall_i=1: every mem_* output holds.
  - stall_i=0, no accept: mem_valid_o<=0; other fields hold.
- Single-cycle ops (all except 11-14): result visible in the cycle after acceptance.
  - Shifts use op_b_i[4:0].
  - SLT/SLTU give 1 or 0.
  - MUL gives the low DATA_WIDTH bits.
  - PASSB gives op_b_i.
  - All arithmetic wraps modulo 2^DATA_WIDTH.
- Divider states: IDLE, BUSY, DONE.
  - IDLE, with valid_i, ops 11-14, stall_i=0, flush_i=0:
    - Divisor 0: no FSM. Result is all-ones for quotient ops, op_a_i for remainder ops. Accepted this cycle.
    - Signed overflow (op_a_i=0x80000000, op_b_i=0xFFFFFFFF, DIV/REM): no FSM. Quotient 0x80000000, remainder 0. Accepted this cycle.
    - Otherwise: latch op, |A| and |B| (absolute values for signed ops) and the input sign bits; count<=0; stall_o=1; go to BUSY.
  - BUSY: stall_o=1; one restoring iteration per cycle; after 32 iterations (count==31) go to DONE.
  - DONE:
    - Sign fixup: quotient negated if the operand signs differed (signed ops); remainder takes the dividend's sign.
    - If stall_i=0: stall_o=0, the held instruction is accepted with the divider result, go to IDLE.
    - Otherwise stay in DONE.
  - Latency: first presented in cycle N; result visible in cycle N+34 when there are no memory stalls.
- stall_o = stall_i || state==BUSY || (state==DONE && stall_i) || (state==IDLE && divider start).
- flush_i: from any state, return to IDLE and accept nothing this cycle. Output register follows the stall_i rules above.
- Reset mid-divide: immediate IDLE; no partial result is emitted.
- Decode must hold every input stable while stall_o=1. The divider uses its latched operands regardless.

Test Plan:
- ADD 5+7, valid_i=1, wr_reg_i=3 -> next cycle mem_valid_o=1, mem_alu_result_o=12, mem_wr_reg_o=3; stall_o=0 throughout.
- DIV -7/2 presented at cycle N -> stall_o high cycles N..N+32, low at N+33; mem_alu_result_o=0xFFFFFFFD at N+34. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14.
- DIVU 9/0 -> next cycle 0xFFFFFFFF, no stall. REM 0x80000000/-1 -> next cycle 0.
- Store (is_store_i=1, access_size WORD, rs2_data_i=0xDEADBEEF) with stall_i=1 for 3 cycles -> mem_* outputs hold; stall_o=1; accepted the cycle stall_i falls.
- DIV started, flush_i=1 at BUSY count 10 -> IDLE next cycle, stall_o=0, no divider result ever appears; the next ADD completes in 1 cycle.
- rst_i low during BUSY -> all mem_* outputs 0 immediately; after release a new DIV 20/3 returns 6 with full latency.
